// File: rtl/onehot_checker_pkg.sv
// Shared types for the one-hot checker: check modes, alarm FSM states and the pass rule.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package onehot_checker_pkg;

    // Check modes, encoded exactly as the 2-bit mode input
    typedef enum logic [1:0] {
        MODE_ONEHOT  = 2'b00,   // popcount == 1
        MODE_ONEHOT0 = 2'b01,   // popcount <= 1
        MODE_EQ      = 2'b10,   // popcount == target
        MODE_LE      = 2'b11    // popcount <= target
    } mode_e;

    // Consecutive-fail supervisor states
    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_WARN  = 2'b01,
        ST_ALARM = 2'b10
    } state_e;

    // Width of the consecutive-fail counter
    localparam int CF_W = 8;

    // Popcount/target width wide enough for the largest legal WIDTH (64 -> 7 bits)
    localparam int PC_MAX_W = 7;

    // Pass rule for one qualified sample. Callers zero-extend popcount and
    // target to PC_MAX_W so a target above WIDTH compares without truncation.
    function automatic logic check_pass(input mode_e                 m,
                                        input logic [PC_MAX_W-1:0] pc,
                                        input logic [PC_MAX_W-1:0] tgt);
        logic ok;
        case (m)
            MODE_ONEHOT:  ok = (pc == PC_MAX_W'(1));
            MODE_ONEHOT0: ok = (pc <= PC_MAX_W'(1));
            MODE_EQ:      ok = (pc == tgt);
            MODE_LE:      ok = (pc <= tgt);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/onehot_checker_popcount_unit.sv
// Combinational popcount of a vector plus a flag for X/Z bits in it.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_vec    [WIDTH]            vector to count
//   o_popcnt [$clog2(WIDTH+1)]  number of bits that are exactly 1 (X/Z excluded)
//   o_xz     [1]                any bit of i_vec is X or Z (always 0 in synthesis)
module popcount_unit #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0]           i_vec,
    output logic [$clog2(WIDTH+1)-1:0] o_popcnt,
    output logic                       o_xz
);

    localparam int PCW = $clog2(WIDTH+1);

    logic [PCW-1:0] w_cnt;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
`ifndef SYNTHESIS
            // Case equality so X/Z bits never contribute to the count
            if (i_vec[i] === 1'b1) begin
                w_cnt = w_cnt + PCW'(1);
            end
`else
            if (i_vec[i]) begin
                w_cnt = w_cnt + PCW'(1);
            end
`endif
        end
    end

    assign o_popcnt = w_cnt;

`ifndef SYNTHESIS
    assign o_xz = $isunknown(i_vec);
`else
    assign o_xz = 1'b0;
`endif

endmodule

// File: rtl/onehot_checker.sv
// One-hot / popcount checker with pass/fail pulses, saturating statistics,
// consecutive-fail alarm FSM and first-fail capture.
// Latency: 1 cycle from sampled inputs to pass/fail/xz_err/popcnt.
// Backpressure: none; every cycle with i_en=1 is checked, i_en=0 freezes the checker.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_en                qualifies i_vec for checking this cycle
//   i_vec [WIDTH]       vector under check
//   i_mode [2]          mode_e: one-hot, one-hot-or-zero, pop==target, pop<=target
//   i_target [PCW]      reference count for MODE_EQ / MODE_LE
//   i_clr               clears counters, alarm and capture (popcnt holds)
//   o_pass, o_fail      one-cycle result pulses, mutually exclusive
//   o_xz_err            with o_fail, the failing vector had X/Z bits
//   o_popcnt [PCW]      popcount of the last qualified vector
//   o_pass_cnt/o_fail_cnt [CNT_W]  saturating statistics
//   o_alarm             sticky, high in ST_ALARM
//   o_cap_vec [WIDTH], o_cap_valid  first failing vector since reset/clr
module onehot_checker
    import onehot_checker_pkg::*;
#(
    parameter int WIDTH      = 5,
    parameter int CNT_W      = 16,
    parameter int FAIL_LIMIT = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [WIDTH-1:0]           i_vec,
    input  logic [1:0]                 i_mode,
    input  logic [$clog2(WIDTH+1)-1:0] i_target,
    input  logic                       i_clr,
    output logic                       o_pass,
    output logic                       o_fail,
    output logic                       o_xz_err,
    output logic [$clog2(WIDTH+1)-1:0] o_popcnt,
    output logic [CNT_W-1:0]           o_pass_cnt,
    output logic [CNT_W-1:0]           o_fail_cnt,
    output logic                       o_alarm,
    output logic [WIDTH-1:0]           o_cap_vec,
    output logic                       o_cap_valid
);

    localparam int             PCW   = $clog2(WIDTH+1);
    localparam logic [CF_W-1:0] LIMIT = CF_W'(FAIL_LIMIT);

    // ------------------------------------------------------------------
    // Combinational check of the current sample
    // ------------------------------------------------------------------
    logic [PCW-1:0] w_popcnt;
    logic           w_xz;
    logic           w_chk_fail;
    logic           w_qual;

    popcount_unit #(
        .WIDTH (WIDTH)
    ) u_popcount (
        .i_vec    (i_vec),
        .o_popcnt (w_popcnt),
        .o_xz     (w_xz)
    );

    // X/Z anywhere in the vector overrides the mode rule
    assign w_chk_fail = w_xz |
                        !check_pass(mode_e'(i_mode),
                                    PC_MAX_W'(w_popcnt),
                                    PC_MAX_W'(i_target));

    // clr discards a check landing in the same cycle
    assign w_qual = i_en && !i_clr;

    // ------------------------------------------------------------------
    // Consecutive-fail FSM
    // ------------------------------------------------------------------
    state_e          r_state;
    state_e          w_state_nxt;
    logic [CF_W-1:0] r_cf_cnt;
    logic [CF_W-1:0] w_cf_nxt;
    logic [CF_W-1:0] w_cf_inc;

    assign w_cf_inc = r_cf_cnt + CF_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_state  <= ST_OK;
            r_cf_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cf_cnt <= w_cf_nxt;
        end
    end

    // Unqualified cycles hold state, so en=0 gaps neither break nor extend a run
    always_comb begin
        w_state_nxt = r_state;
        w_cf_nxt    = r_cf_cnt;
        if (w_qual) begin
            case (r_state)
                ST_OK: begin
                    if (w_chk_fail) begin
                        w_cf_nxt    = CF_W'(1);
                        w_state_nxt = (LIMIT <= CF_W'(1)) ? ST_ALARM : ST_WARN;
                    end
                end
                ST_WARN: begin
                    if (w_chk_fail) begin
                        w_cf_nxt = w_cf_inc;
                        if (w_cf_inc >= LIMIT) begin
                            w_state_nxt = ST_ALARM;
                        end
                    end else begin
                        w_cf_nxt    = '0;
                        w_state_nxt = ST_OK;
                    end
                end
                ST_ALARM: begin
                    w_state_nxt = ST_ALARM;
                end
                default: begin
                    w_state_nxt = ST_OK;
                    w_cf_nxt    = '0;
                end
            endcase
        end
    end

    assign o_alarm = (r_state == ST_ALARM);

    // ------------------------------------------------------------------
    // Result pulses, statistics and first-fail capture
    // ------------------------------------------------------------------
    logic             r_pass;
    logic             r_fail;
    logic             r_xz_err;
    logic [PCW-1:0]   r_popcnt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [WIDTH-1:0] r_cap_vec;
    logic             r_cap_valid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_xz_err    <= 1'b0;
            r_popcnt    <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_cap_vec   <= '0;
            r_cap_valid <= 1'b0;
        end else begin
            r_pass   <= 1'b0;
            r_fail   <= 1'b0;
            r_xz_err <= 1'b0;
            if (i_clr) begin
                // popcnt deliberately holds across clr
                r_pass_cnt  <= '0;
                r_fail_cnt  <= '0;
                r_cap_vec   <= '0;
                r_cap_valid <= 1'b0;
            end else if (i_en) begin
                r_popcnt <= w_popcnt;
                r_pass   <= !w_chk_fail;
                r_fail   <= w_chk_fail;
                r_xz_err <= w_xz;
                if (w_chk_fail) begin
                    if (r_fail_cnt != {CNT_W{1'b1}}) begin
                        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                    end
                    if (!r_cap_valid) begin
                        r_cap_vec   <= i_vec;
                        r_cap_valid <= 1'b1;
                    end
                end else begin
                    if (r_pass_cnt != {CNT_W{1'b1}}) begin
                        r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_pass      = r_pass;
    assign o_fail      = r_fail;
    assign o_xz_err    = r_xz_err;
    assign o_popcnt    = r_popcnt;
    assign o_pass_cnt  = r_pass_cnt;
    assign o_fail_cnt  = r_fail_cnt;
    assign o_cap_vec   = r_cap_vec;
    assign o_cap_valid = r_cap_valid;

endmodule

// File: tb/tb_onehot_checker.sv
// Directed self-checking bench for onehot_checker (WIDTH=5, CNT_W=2, FAIL_LIMIT=3).
// Latency: results checked 1 time unit after the edge that sampled the inputs.
// Backpressure: n/a.
module tb_onehot_checker;
    import onehot_checker_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] vec;
    logic [1:0] mode;
    logic [2:0] target;
    logic       clr;
    logic       pass;
    logic       fail;
    logic       xz_err;
    logic [2:0] popcnt;
    logic [1:0] pass_cnt;
    logic [1:0] fail_cnt;
    logic       alarm;
    logic [4:0] cap_vec;
    logic       cap_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onehot_checker #(
        .WIDTH      (5),
        .CNT_W      (2),
        .FAIL_LIMIT (3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_vec       (vec),
        .i_mode      (mode),
        .i_target    (target),
        .i_clr       (clr),
        .o_pass      (pass),
        .o_fail      (fail),
        .o_xz_err    (xz_err),
        .o_popcnt    (popcnt),
        .o_pass_cnt  (pass_cnt),
        .o_fail_cnt  (fail_cnt),
        .o_alarm     (alarm),
        .o_cap_vec   (cap_vec),
        .o_cap_valid (cap_valid)
    );

    // Reference popcount: only bits that are exactly 1 count
    function automatic int model_pop(input logic [4:0] v);
        int pc = 0;
        for (int i = 0; i < 5; i++) begin
            if (v[i] === 1'b1) pc++;
        end
        return pc;
    endfunction

    // Reference pass rule, independent of the package helper
    function automatic logic model_pass(input logic [1:0] m, input logic [2:0] t,
                                        input logic [4:0] v);
        int pc;
        if ($isunknown(v)) return 1'b0;
        pc = model_pop(v);
        case (m)
            2'b00:   return pc == 1;
            2'b01:   return pc <= 1;
            2'b10:   return pc == int'(t);
            default: return pc <= int'(t);
        endcase
    endfunction

    logic m_pass;
    assign m_pass = model_pass(mode, target, vec);

    a_rule: assert property (@(posedge clk) disable iff (rst)
        (en && !clr) |=> (pass == $past(m_pass)));

    a_excl: assert property (@(posedge clk) !(pass && fail));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [1:0] m, input logic [2:0] t, input logic [4:0] v);
        en = 1'b1; mode = m; target = t; vec = v;
        step();
    endtask

    task automatic do_clr();
        en = 1'b0; clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin : stim
        logic [4:0] xv;
        logic       exp_p;

        rst = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'b00; target = 3'd0; vec = 5'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_pass", 64'(pass), 64'd0);
        check("rst_fail", 64'(fail), 64'd0);
        check("rst_xz", 64'(xz_err), 64'd0);
        check("rst_popcnt", 64'(popcnt), 64'd0);
        check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
        check("rst_fail_cnt", 64'(fail_cnt), 64'd0);
        check("rst_alarm", 64'(alarm), 64'd0);
        check("rst_cap_valid", 64'(cap_valid), 64'd0);
        check("rst_cap_vec", 64'(cap_vec), 64'd0);

        // One-hot: pass then fail
        sample(2'b00, 3'd0, 5'b00100);
        check("oh_pass", 64'(pass), 64'd1);
        check("oh_pass_fail", 64'(fail), 64'd0);
        check("oh_pass_pop", 64'(popcnt), 64'd1);
        sample(2'b00, 3'd0, 5'b01100);
        check("oh_fail", 64'(fail), 64'd1);
        check("oh_fail_pass", 64'(pass), 64'd0);
        check("oh_fail_pop", 64'(popcnt), 64'd2);
        check("oh_fail_cnt", 64'(fail_cnt), 64'd1);
        check("oh_pass_cnt", 64'(pass_cnt), 64'd1);
        check("oh_cap_vec", 64'(cap_vec), 64'b01100);
        en = 1'b0;
        step();
        check("idle_pass", 64'(pass), 64'd0);
        check("idle_fail", 64'(fail), 64'd0);
        check("idle_pop_hold", 64'(popcnt), 64'd2);
        do_clr();
        check("clr_fail_cnt", 64'(fail_cnt), 64'd0);
        check("clr_cap_valid", 64'(cap_valid), 64'd0);
        check("clr_pop_hold", 64'(popcnt), 64'd2);

        // X/Z bit; expectation derived from whatever the simulator holds in the vector
        xv = 5'b001x0;
        exp_p = model_pass(2'b00, 3'd0, xv);
        sample(2'b00, 3'd0, xv);
        check("xz_pass", 64'(pass), 64'(exp_p));
        check("xz_fail", 64'(fail), 64'(!exp_p));
        check("xz_flag", 64'(xz_err), 64'($isunknown(xv)));
        check("xz_pop", 64'(popcnt), 64'(model_pop(xv)));
        check("xz_cap_valid", 64'(cap_valid), 64'(!exp_p));
        if (!exp_p) check("xz_cap_vec", 64'(cap_vec), 64'(xv));
        do_clr();

        // Count modes, including a target above WIDTH
        sample(2'b10, 3'd3, 5'b11010);
        check("eq3_pass", 64'(pass), 64'd1);
        check("eq3_pop", 64'(popcnt), 64'd3);
        sample(2'b10, 3'd3, 5'b11110);
        check("eq3_fail", 64'(fail), 64'd1);
        check("eq3_fail_pop", 64'(popcnt), 64'd4);
        sample(2'b11, 3'd3, 5'b00000);
        check("le3_zero_pass", 64'(pass), 64'd1);
        sample(2'b10, 3'd7, 5'b11111);
        check("eq7_fail", 64'(fail), 64'd1);
        check("eq7_pop", 64'(popcnt), 64'd5);
        sample(2'b11, 3'd7, 5'b11111);
        check("le7_pass", 64'(pass), 64'd1);
        sample(2'b01, 3'd0, 5'b00000);
        check("oh0_zero_pass", 64'(pass), 64'd1);
        sample(2'b01, 3'd0, 5'b00011);
        check("oh0_two_fail", 64'(fail), 64'd1);
        sample(2'b00, 3'd0, 5'b00000);
        check("oh_zero_fail", 64'(fail), 64'd1);
        check("sat_pass_cnt", 64'(pass_cnt), 64'd3);
        check("sat_fail_cnt", 64'(fail_cnt), 64'd3);
        check("warn2_alarm", 64'(alarm), 64'd0);
        check("warn2_state", 64'(dut.r_state), 64'(ST_WARN));
        check("warn2_cf", 64'(dut.r_cf_cnt), 64'd2);

        // Reset in the middle of a fail run
        en = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_state", 64'(dut.r_state), 64'(ST_OK));
        check("midrst_pop", 64'(popcnt), 64'd0);
        sample(2'b00, 3'd0, 5'b00000);
        check("postrst_state", 64'(dut.r_state), 64'(ST_WARN));
        check("postrst_cf", 64'(dut.r_cf_cnt), 64'd1);
        check("postrst_alarm", 64'(alarm), 64'd0);
        do_clr();

        // Three fails separated by idle cycles raise the alarm; capture keeps the first
        sample(2'b00, 3'd0, 5'b10001);
        check("run1_cap", 64'(cap_vec), 64'b10001);
        en = 1'b0;
        step();
        step();
        check("gap_alarm", 64'(alarm), 64'd0);
        sample(2'b00, 3'd0, 5'b00000);
        check("run2_alarm", 64'(alarm), 64'd0);
        en = 1'b0;
        step();
        sample(2'b00, 3'd0, 5'b11000);
        check("run3_alarm", 64'(alarm), 64'd1);
        check("run3_cap_kept", 64'(cap_vec), 64'b10001);
        sample(2'b00, 3'd0, 5'b00100);
        check("alarm_sticky", 64'(alarm), 64'd1);
        do_clr();
        check("clr_alarm", 64'(alarm), 64'd0);

        // Pass after two fails returns to OK
        sample(2'b00, 3'd0, 5'b00000);
        sample(2'b00, 3'd0, 5'b00011);
        sample(2'b00, 3'd0, 5'b01000);
        check("recover_state", 64'(dut.r_state), 64'(ST_OK));
        check("recover_cf", 64'(dut.r_cf_cnt), 64'd0);
        sample(2'b00, 3'd0, 5'b00000);
        check("recover_alarm", 64'(alarm), 64'd0);
        do_clr();

        // Saturation on five passes, then clr beating a qualified check
        for (int i = 0; i < 5; i++) begin
            sample(2'b00, 3'd0, 5'b00001);
            check("sat_walk", 64'(pass_cnt), 64'((i + 1 > 3) ? 3 : i + 1));
        end
        en = 1'b1; clr = 1'b1; vec = 5'b00011;
        step();
        clr = 1'b0; en = 1'b0;
        check("clr_en_pass", 64'(pass), 64'd0);
        check("clr_en_fail", 64'(fail), 64'd0);
        check("clr_en_pass_cnt", 64'(pass_cnt), 64'd0);
        check("clr_en_fail_cnt", 64'(fail_cnt), 64'd0);
        check("clr_en_pop", 64'(popcnt), 64'd1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
